// File: rtl/bot_frame_latch_if.sv
// Bundle between the Rojobot register outputs, the frame latch and its consumers
// (icon generator and CPU interrupt logic).
interface bot_frame_latch_if #(
  parameter int unsigned CNT_W = 8
);
  logic             upd_sysregs;
  logic [31:0]      LocX_in;
  logic [31:0]      LocY_in;
  logic [7:0]       BotInfo_in;
  logic             frame_start;
  logic             IO_INT_ACK;
  logic [31:0]      LocX_reg;
  logic [31:0]      LocY_reg;
  logic [7:0]       BotInfo_reg;
  logic             IO_BotUpdt_Sync;
  logic             pending;
  logic [CNT_W-1:0] overrun_cnt;

  // Master drives the update/timing/ack side and observes the committed state.
  modport master (
    output upd_sysregs, LocX_in, LocY_in, BotInfo_in, frame_start, IO_INT_ACK,
    input  LocX_reg, LocY_reg, BotInfo_reg, IO_BotUpdt_Sync, pending, overrun_cnt
  );

  modport slave (
    input  upd_sysregs, LocX_in, LocY_in, BotInfo_in, frame_start, IO_INT_ACK,
    output LocX_reg, LocY_reg, BotInfo_reg, IO_BotUpdt_Sync, pending, overrun_cnt
  );
endinterface

// File: rtl/bot_frame_latch.sv
// Frame-synchronous latch: shadows Rojobot updates and commits them to the icon-facing
// registers only on frame_start, raising a sticky update interrupt on each commit.
module bot_frame_latch #(
  parameter int unsigned MAX_COORD = 127,
  parameter int unsigned CNT_W     = 8
) (
  input logic              clk,
  input logic              reset,
  bot_frame_latch_if.slave bus
);

  localparam logic [31:0] MaxCoord = 32'(MAX_COORD);

  typedef enum logic {StIdle, StPending} state_e;

  state_e           state_q;
  logic [31:0]      shadow_x_q;
  logic [31:0]      shadow_y_q;
  logic [7:0]       shadow_info_q;
  logic [31:0]      loc_x_q;
  logic [31:0]      loc_y_q;
  logic [7:0]       info_q;
  logic             irq_q;
  logic [CNT_W-1:0] ovr_q;

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v > MaxCoord) ? MaxCoord : v;
  endfunction

  logic commit;
  assign commit = bus.frame_start && (bus.upd_sysregs || (state_q == StPending));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      shadow_x_q    <= '0;
      shadow_y_q    <= '0;
      shadow_info_q <= '0;
      loc_x_q       <= '0;
      loc_y_q       <= '0;
      info_q        <= '0;
      irq_q         <= 1'b0;
      ovr_q         <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.upd_sysregs && bus.frame_start) begin
            loc_x_q <= sat(bus.LocX_in);
            loc_y_q <= sat(bus.LocY_in);
            info_q  <= bus.BotInfo_in;
          end else if (bus.upd_sysregs) begin
            shadow_x_q    <= sat(bus.LocX_in);
            shadow_y_q    <= sat(bus.LocY_in);
            shadow_info_q <= bus.BotInfo_in;
            state_q       <= StPending;
          end
        end
        StPending: begin
          // Any update arriving here discards older shadow data, bypass included.
          if (bus.upd_sysregs && (ovr_q != '1)) begin
            ovr_q <= ovr_q + 1'b1;
          end
          if (bus.upd_sysregs && bus.frame_start) begin
            loc_x_q <= sat(bus.LocX_in);
            loc_y_q <= sat(bus.LocY_in);
            info_q  <= bus.BotInfo_in;
            state_q <= StIdle;
          end else if (bus.upd_sysregs) begin
            shadow_x_q    <= sat(bus.LocX_in);
            shadow_y_q    <= sat(bus.LocY_in);
            shadow_info_q <= bus.BotInfo_in;
          end else if (bus.frame_start) begin
            loc_x_q <= shadow_x_q;
            loc_y_q <= shadow_y_q;
            info_q  <= shadow_info_q;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Commit beats acknowledge when both land in the same cycle.
      if (commit) begin
        irq_q <= 1'b1;
      end else if (bus.IO_INT_ACK) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign bus.LocX_reg        = loc_x_q;
  assign bus.LocY_reg        = loc_y_q;
  assign bus.BotInfo_reg     = info_q;
  assign bus.IO_BotUpdt_Sync = irq_q;
  assign bus.pending         = (state_q == StPending);
  assign bus.overrun_cnt     = ovr_q;

endmodule

// File: tb/tb_bot_frame_latch.sv
// Directed bench for bot_frame_latch: each task drives one scenario and checks inline.
module tb_bot_frame_latch;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  bot_frame_latch_if #(.CNT_W(8)) bus ();

  bot_frame_latch #(
    .MAX_COORD(127),
    .CNT_W    (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, let the DUT sample them, then return inputs to idle.
  task automatic drive(input logic upd, input logic [31:0] x, input logic [31:0] y,
                       input logic [7:0] info, input logic fs, input logic ack);
    bus.upd_sysregs = upd;
    bus.LocX_in     = x;
    bus.LocY_in     = y;
    bus.BotInfo_in  = info;
    bus.frame_start = fs;
    bus.IO_INT_ACK  = ack;
    step();
    bus.upd_sysregs = 1'b0;
    bus.LocX_in     = '0;
    bus.LocY_in     = '0;
    bus.BotInfo_in  = '0;
    bus.frame_start = 1'b0;
    bus.IO_INT_ACK  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    n_tests++;
    if (bus.LocX_reg !== 32'd0 || bus.pending !== 1'b0 || bus.IO_BotUpdt_Sync !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: x=%0d pend=%b irq=%b want 0 0 0",
               bus.LocX_reg, bus.pending, bus.IO_BotUpdt_Sync);
    end
    // Make the outputs nonzero, then reset mid-cycle and look before any edge.
    drive(1'b1, 32'd9, 32'd8, 8'h77, 1'b1, 1'b0);
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if (bus.LocX_reg !== 32'd0 || bus.LocY_reg !== 32'd0 || bus.BotInfo_reg !== 8'h00 ||
        bus.IO_BotUpdt_Sync !== 1'b0 || bus.overrun_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_async: x=%0d y=%0d info=%h irq=%b ovr=%0d want all 0",
               bus.LocX_reg, bus.LocY_reg, bus.BotInfo_reg, bus.IO_BotUpdt_Sync,
               bus.overrun_cnt);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_update();
    drive(1'b1, 32'd10, 32'd20, 8'h03, 1'b0, 1'b0);
    n_tests++;
    if (bus.pending !== 1'b1 || bus.LocX_reg !== 32'd0 || bus.IO_BotUpdt_Sync !== 1'b0) begin
      n_fail++;
      $display("FAIL single_shadow: pend=%b x=%0d irq=%b want 1 0 0",
               bus.pending, bus.LocX_reg, bus.IO_BotUpdt_Sync);
    end
    drive(1'b0, 32'd0, 32'd0, 8'h00, 1'b1, 1'b0);
    n_tests++;
    if (bus.LocX_reg !== 32'd10 || bus.LocY_reg !== 32'd20 || bus.BotInfo_reg !== 8'h03 ||
        bus.IO_BotUpdt_Sync !== 1'b1 || bus.pending !== 1'b0) begin
      n_fail++;
      $display("FAIL single_commit: x=%0d y=%0d info=%h irq=%b pend=%b want 10 20 03 1 0",
               bus.LocX_reg, bus.LocY_reg, bus.BotInfo_reg, bus.IO_BotUpdt_Sync, bus.pending);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 3; i++) drive(1'b1, 32'(i), 32'd0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 8'h00, 1'b1, 1'b0);
    n_tests++;
    if (bus.LocX_reg !== 32'd3 || bus.overrun_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL overrun_three: x=%0d ovr=%0d want 3 2", bus.LocX_reg, bus.overrun_cnt);
    end
  endtask

  task automatic test_coincident();
    drive(1'b1, 32'd5, 32'd6, 8'h11, 1'b1, 1'b0);
    n_tests++;
    if (bus.LocX_reg !== 32'd5 || bus.LocY_reg !== 32'd6 || bus.overrun_cnt !== 8'd2 ||
        bus.pending !== 1'b0) begin
      n_fail++;
      $display("FAIL coinc_idle: x=%0d y=%0d ovr=%0d pend=%b want 5 6 2 0",
               bus.LocX_reg, bus.LocY_reg, bus.overrun_cnt, bus.pending);
    end
    drive(1'b1, 32'd6, 32'd6, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 32'd7, 32'd8, 8'h33, 1'b1, 1'b0);
    n_tests++;
    if (bus.LocX_reg !== 32'd7 || bus.LocY_reg !== 32'd8 || bus.BotInfo_reg !== 8'h33 ||
        bus.overrun_cnt !== 8'd3 || bus.pending !== 1'b0 || bus.IO_BotUpdt_Sync !== 1'b1) begin
      n_fail++;
      $display("FAIL coinc_pending: x=%0d y=%0d info=%h ovr=%0d pend=%b irq=%b want 7 8 33 3 0 1",
               bus.LocX_reg, bus.LocY_reg, bus.BotInfo_reg, bus.overrun_cnt, bus.pending,
               bus.IO_BotUpdt_Sync);
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 8'hA5, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 8'h00, 1'b1, 1'b0);
    n_tests++;
    if (bus.LocX_reg !== 32'd127 || bus.LocY_reg !== 32'd127 || bus.BotInfo_reg !== 8'hA5) begin
      n_fail++;
      $display("FAIL sat_shadow: x=%0d y=%0d info=%h want 127 127 a5",
               bus.LocX_reg, bus.LocY_reg, bus.BotInfo_reg);
    end
    drive(1'b1, 32'h8000_0000, 32'd126, 8'hFF, 1'b1, 1'b0);
    n_tests++;
    if (bus.LocX_reg !== 32'd127 || bus.LocY_reg !== 32'd126 || bus.BotInfo_reg !== 8'hFF) begin
      n_fail++;
      $display("FAIL sat_bypass: x=%0d y=%0d info=%h want 127 126 ff",
               bus.LocX_reg, bus.LocY_reg, bus.BotInfo_reg);
    end
    drive(1'b1, 32'd128, 32'd127, 8'h00, 1'b1, 1'b0);
    n_tests++;
    if (bus.LocX_reg !== 32'd127 || bus.LocY_reg !== 32'd127) begin
      n_fail++;
      $display("FAIL sat_edge: x=%0d y=%0d want 127 127", bus.LocX_reg, bus.LocY_reg);
    end
  endtask

  task automatic test_handshake();
    // Interrupt is still set from the previous commit.
    drive(1'b0, 32'd0, 32'd0, 8'h00, 1'b0, 1'b1);
    n_tests++;
    if (bus.IO_BotUpdt_Sync !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_clear: irq=%b want 0", bus.IO_BotUpdt_Sync);
    end
    drive(1'b0, 32'd0, 32'd0, 8'h00, 1'b1, 1'b0);
    n_tests++;
    if (bus.IO_BotUpdt_Sync !== 1'b0 || bus.LocX_reg !== 32'd127) begin
      n_fail++;
      $display("FAIL idle_frame: irq=%b x=%0d want 0 127", bus.IO_BotUpdt_Sync, bus.LocX_reg);
    end
    drive(1'b1, 32'd1, 32'd2, 8'h04, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 8'h00, 1'b1, 1'b1);
    n_tests++;
    if (bus.IO_BotUpdt_Sync !== 1'b1 || bus.LocX_reg !== 32'd1) begin
      n_fail++;
      $display("FAIL ack_vs_commit: irq=%b x=%0d want 1 1", bus.IO_BotUpdt_Sync, bus.LocX_reg);
    end
    drive(1'b0, 32'd0, 32'd0, 8'h00, 1'b0, 1'b1);
    n_tests++;
    if (bus.IO_BotUpdt_Sync !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_held: irq=%b want 0", bus.IO_BotUpdt_Sync);
    end
  endtask

  task automatic test_overrun_saturate();
    for (int i = 0; i < 300; i++) drive(1'b1, 32'(i), 32'd3, 8'h05, 1'b0, 1'b0);
    n_tests++;
    if (bus.overrun_cnt !== 8'd255 || bus.pending !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sat: ovr=%0d pend=%b want 255 1", bus.overrun_cnt, bus.pending);
    end
    drive(1'b0, 32'd0, 32'd0, 8'h00, 1'b1, 1'b0);
    n_tests++;
    if (bus.LocX_reg !== 32'd127 || bus.LocY_reg !== 32'd3 || bus.overrun_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL ovr_sat_commit: x=%0d y=%0d ovr=%0d want 127 3 255",
               bus.LocX_reg, bus.LocY_reg, bus.overrun_cnt);
    end
  endtask

  task automatic test_reset_pending();
    drive(1'b1, 32'd50, 32'd60, 8'h07, 1'b0, 1'b0);
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if (bus.pending !== 1'b0 || bus.overrun_cnt !== 8'd0 || bus.LocX_reg !== 32'd0) begin
      n_fail++;
      $display("FAIL rstpend_async: pend=%b ovr=%0d x=%0d want 0 0 0",
               bus.pending, bus.overrun_cnt, bus.LocX_reg);
    end
    step();
    reset = 1'b0;
    step();
    drive(1'b0, 32'd0, 32'd0, 8'h00, 1'b1, 1'b0);
    n_tests++;
    if (bus.LocX_reg !== 32'd0 || bus.LocY_reg !== 32'd0 || bus.BotInfo_reg !== 8'h00 ||
        bus.pending !== 1'b0 || bus.IO_BotUpdt_Sync !== 1'b0) begin
      n_fail++;
      $display("FAIL rstpend_frame: x=%0d y=%0d info=%h pend=%b irq=%b want 0 0 00 0 0",
               bus.LocX_reg, bus.LocY_reg, bus.BotInfo_reg, bus.pending, bus.IO_BotUpdt_Sync);
    end
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    reset           = 1'b1;
    bus.upd_sysregs = 1'b0;
    bus.LocX_in     = '0;
    bus.LocY_in     = '0;
    bus.BotInfo_in  = '0;
    bus.frame_start = 1'b0;
    bus.IO_INT_ACK  = 1'b0;
    test_reset();
    test_single_update();
    test_overrun();
    test_coincident();
    test_saturation();
    test_handshake();
    test_overrun_saturate();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
